// File: rtl/loader_pkg.sv
// Shared types and constants for the serial boot loader.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum
  } load_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, mid-bit sampling timer and LSB-first shifter.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

  rx_state_e   state;
  logic        rx_meta, rx_sync, rx_prev;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Synchronizer resets to the idle-high line level so reset release is not a start edge.
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RxIdle;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= uart_rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        RxIdle: begin
          if (rx_prev && !rx_sync) begin
            state <= RxStart;
            cnt   <= '0;
          end
        end
        RxStart: begin
          if (cnt == 16'(HALF_BIT - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RxIdle : RxData;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RxData: begin
          if (cnt == 16'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RxStop;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RxStop: begin
          if (cnt == 16'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            state <= RxIdle;
            if (rx_sync) begin
              byte_out   <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= RxIdle;
      endcase
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Serial boot loader: parses sync/length/data/checksum frames and writes little-endian words
// to sequential word-aligned addresses.
module mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned GAP_TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  output logic        loader_busy,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned CAPACITY = 1 << (ADDR_WIDTH - 2);

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_err;

  load_state_e state;
  logic [15:0] len, word_idx, len_rx;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic [7:0]  csum;
  logic [31:0] gap_cnt;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_err)
  );

  always_comb len_rx = {rx_byte, len[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      len         <= '0;
      word_idx    <= '0;
      byte_cnt    <= '0;
      word_buf    <= '0;
      csum        <= '0;
      gap_cnt     <= '0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_we      <= 1'b0;
      loader_busy <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      if (rx_err || (state != StIdle && !rx_valid && gap_cnt == GAP_TIMEOUT - 1)) begin
        state       <= StIdle;
        loader_busy <= 1'b0;
        load_err    <= 1'b1;
        gap_cnt     <= '0;
      end else begin
        gap_cnt <= (state == StIdle || rx_valid) ? '0 : gap_cnt + 32'd1;
        if (rx_valid) begin
          unique case (state)
            StIdle: begin
              if (rx_byte == SYNC_BYTE) begin
                state       <= StLenLo;
                loader_busy <= 1'b1;
                load_err    <= 1'b0;
                csum        <= '0;
                word_idx    <= '0;
                byte_cnt    <= '0;
              end
            end
            StLenLo: begin
              len   <= {8'd0, rx_byte};
              state <= StLenHi;
            end
            StLenHi: begin
              len <= len_rx;
              if (32'(len_rx) > CAPACITY) begin
                state       <= StIdle;
                loader_busy <= 1'b0;
                load_err    <= 1'b1;
              end else begin
                state <= (len_rx == 16'd0) ? StCsum : StData;
              end
            end
            StData: begin
              csum     <= csum ^ rx_byte;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                mem_we   <= 1'b1;
                mem_addr <= {14'd0, word_idx, 2'b00};
                mem_data <= {rx_byte, word_buf};
                word_idx <= word_idx + 16'd1;
                if (word_idx + 16'd1 == len) state <= StCsum;
              end else begin
                word_buf <= {rx_byte, word_buf[23:8]};
              end
            end
            StCsum: begin
              state       <= StIdle;
              loader_busy <= 1'b0;
              if (rx_byte == csum) load_done <= 1'b1;
              else                 load_err  <= 1'b1;
            end
            default: state <= StIdle;
          endcase
        end
      end
    end
  end

endmodule
